// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control codes, result-source codes
// and the registered control bundle carried from decode into execute.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        alu_src;
    logic        branch;
    logic        jump;
    alu_ctrl_e   alu_ctrl;
    logic        illegal;
  } ctrl_t;

  // sltu folds onto slt and srai onto srl: the ALU has no unsigned/arith variants.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic sub);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetched instruction, register-file port, write-back bypass
// and the ID/EX register outputs.
interface decode_stage_if #(parameter int XLEN = 32);
  // ValidD qualifies InstrD/PCD/PCPlus4D; there is no ready: stall=1 holds the
  // ID/EX register so the upstream stage must hold its outputs, flush=1 bubbles it.
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic            stall;
  logic            flush;
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            ALUSrcE;
  logic            BranchE;
  logic            JumpE;
  logic [2:0]      ALUControlE;
  logic            ValidE;
  logic            IllegalE;

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, stall, flush,
           RD1, RD2, RegWriteW, RdW, ResultW,
    input  A1, A2, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, ValidE, IllegalE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, stall, flush,
           RD1, RD2, RegWriteW, RdW, ResultW,
    output A1, A2, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, ValidE, IllegalE
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/J/U format from the opcode
// and sign-extends from bit 31. Formats without an immediate yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_LOAD, OP_IALU, OP_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, write-back bypass
// into the read data, and the ID/EX pipeline register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic            fwd1;
  logic            fwd2;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc4_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;

  assign opcode = bus.InstrD[6:0];
  assign funct3 = bus.InstrD[14:12];
  assign rs1    = bus.InstrD[19:15];
  assign rs2    = bus.InstrD[24:20];
  assign rd     = bus.InstrD[11:7];

  assign bus.A1 = rs1;
  assign bus.A2 = rs2;

  imm_gen u_imm_gen (
    .instr (bus.InstrD),
    .imm   (imm)
  );

  // A register written back this cycle is not yet visible in the file's read data.
  assign fwd1 = bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == rs1);
  assign fwd2 = bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == rs2);

  always_comb begin
    ctrl_d = '0;
    if (bus.ValidD) begin
      ctrl_d.valid = 1'b1;
      case (opcode)
        OP_R: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_ctrl  = alu_from_funct3(funct3, bus.InstrD[30]);
        end
        OP_IALU: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_ctrl  = alu_from_funct3(funct3, 1'b0);
        end
        OP_LOAD: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.result_src = RES_MEM;
        end
        OP_STORE: begin
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
        OP_BRANCH: begin
          ctrl_d.branch   = 1'b1;
          ctrl_d.alu_ctrl = ALU_SUB;
        end
        OP_JAL, OP_JALR: begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.alu_src    = 1'b1;
          ctrl_d.result_src = RES_PC4;
        end
        OP_LUI, OP_AUIPC: begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
        default: ctrl_d.illegal = 1'b1;
      endcase
      if (rd == 5'd0) ctrl_d.reg_write = 1'b0;
    end
  end

  // Flush only clears control; the data fields of a bubble are never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e <= '0;
      rd1_e  <= '0;
      rd2_e  <= '0;
      imm_e  <= '0;
      pc_e   <= '0;
      pc4_e  <= '0;
      rs1_e  <= '0;
      rs2_e  <= '0;
      rd_e   <= '0;
    end else if (bus.flush) begin
      ctrl_e <= '0;
    end else if (!bus.stall) begin
      ctrl_e <= ctrl_d;
      rd1_e  <= fwd1 ? bus.ResultW : bus.RD1;
      rd2_e  <= fwd2 ? bus.ResultW : bus.RD2;
      imm_e  <= imm;
      pc_e   <= bus.PCD;
      pc4_e  <= bus.PCPlus4D;
      rs1_e  <= rs1;
      rs2_e  <= rs2;
      rd_e   <= rd;
    end
  end

  assign bus.RD1E        = rd1_e;
  assign bus.RD2E        = rd2_e;
  assign bus.ImmExtE     = imm_e;
  assign bus.PCE         = pc_e;
  assign bus.PCPlus4E    = pc4_e;
  assign bus.Rs1E        = rs1_e;
  assign bus.Rs2E        = rs2_e;
  assign bus.RdE         = rd_e;
  assign bus.ValidE      = ctrl_e.valid;
  assign bus.RegWriteE   = ctrl_e.reg_write;
  assign bus.MemWriteE   = ctrl_e.mem_write;
  assign bus.ResultSrcE  = ctrl_e.result_src;
  assign bus.ALUSrcE     = ctrl_e.alu_src;
  assign bus.BranchE     = ctrl_e.branch;
  assign bus.JumpE       = ctrl_e.jump;
  assign bus.ALUControlE = ctrl_e.alu_ctrl;
  assign bus.IllegalE    = ctrl_e.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal cases plus randomized instructions,
// stalls, flushes and resets checked every cycle against a table-driven model.
module tb_decode_stage;

  localparam int CARE_FLUSH = 0;
  localparam int CARE_CTRL  = 1;
  localparam int CARE_ALL   = 2;

  // ALU code selected by funct3 (add, sll, slt, sltu->slt, xor, srl, or, and)
  localparam logic [2:0] F3_ALU [8] = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd4, 3'd7, 3'd3, 3'd2};
  localparam logic [6:0] LEGAL_OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                           7'h6F, 7'h67, 7'h37, 7'h17};

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic        memw;
    logic [1:0]  rsrc;
    logic        alusrc;
    logic        br;
    logic        jmp;
    logic [2:0]  aluc;
    logic        ill;
    logic        imm_care;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   printed = 0;
  exp_t exp_q[$];
  int   care_q[$];
  exp_t cur;
  int   cur_care;
  bit   model_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] pc4, input logic [31:0] rd1,
                                        input logic [31:0] rd2, input logic rw_w,
                                        input logic [4:0] rd_w, input logic [31:0] res_w,
                                        input logic vld);
    exp_t e;
    logic s;
    e     = '0;
    s     = ins[31];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.pc4 = pc4;
    e.rd1 = (rw_w && rd_w != 0 && rd_w == ins[19:15]) ? res_w : rd1;
    e.rd2 = (rw_w && rd_w != 0 && rd_w == ins[24:20]) ? res_w : rd2;
    e.imm_care = 1'b1;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: e.imm = {{20{s}}, ins[31:20]};
      7'h23: e.imm = {{20{s}}, ins[31:25], ins[11:7]};
      7'h63: e.imm = {{19{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
      7'h6F: e.imm = {{11{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
      7'h37, 7'h17: e.imm = {ins[31:12], 12'h000};
      default: e.imm_care = 1'b0;
    endcase
    if (!vld) return e;
    e.valid = 1'b1;
    case (ins[6:0])
      7'h33: begin e.regw = 1; e.aluc = (ins[14:12] == 0 && ins[30]) ? 3'd1 : F3_ALU[ins[14:12]]; end
      7'h13: begin e.regw = 1; e.alusrc = 1; e.aluc = F3_ALU[ins[14:12]]; end
      7'h03: begin e.regw = 1; e.alusrc = 1; e.rsrc = 2'd1; end
      7'h23: begin e.memw = 1; e.alusrc = 1; end
      7'h63: begin e.br = 1; e.aluc = 3'd1; end
      7'h6F, 7'h67: begin e.regw = 1; e.jmp = 1; e.alusrc = 1; e.rsrc = 2'd2; end
      7'h37, 7'h17: begin e.regw = 1; e.alusrc = 1; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.regw = 0;
    return e;
  endfunction

  // Reference model of the ID/EX register, one expectation per clock edge.
  always @(posedge clk) begin
    if (rst) begin
      cur          = '0;
      cur.imm_care = 1'b1;
      cur_care     = CARE_ALL;
      model_live   = 1'b1;
    end else if (bus.flush) begin
      cur.valid = 0; cur.regw = 0; cur.memw = 0;
      cur.br = 0; cur.jmp = 0; cur.ill = 0;
      cur_care = CARE_FLUSH;
    end else if (!bus.stall) begin
      cur = model_decode(bus.InstrD, bus.PCD, bus.PCPlus4D, bus.RD1, bus.RD2,
                         bus.RegWriteW, bus.RdW, bus.ResultW, bus.ValidD);
      cur_care = bus.ValidD ? CARE_ALL : CARE_CTRL;
    end
    if (model_live) begin
      exp_q.push_back(cur);
      care_q.push_back(cur_care);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (model_live) begin
      chk("A1", {27'b0, bus.A1}, {27'b0, bus.InstrD[19:15]});
      chk("A2", {27'b0, bus.A2}, {27'b0, bus.InstrD[24:20]});
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = care_q.pop_front();
        chk("ValidE",    {31'b0, bus.ValidE},    {31'b0, e.valid});
        chk("RegWriteE", {31'b0, bus.RegWriteE}, {31'b0, e.regw});
        chk("MemWriteE", {31'b0, bus.MemWriteE}, {31'b0, e.memw});
        chk("BranchE",   {31'b0, bus.BranchE},   {31'b0, e.br});
        chk("JumpE",     {31'b0, bus.JumpE},     {31'b0, e.jmp});
        chk("IllegalE",  {31'b0, bus.IllegalE},  {31'b0, e.ill});
        if (c >= CARE_CTRL) begin
          chk("ResultSrcE",  {30'b0, bus.ResultSrcE},  {30'b0, e.rsrc});
          chk("ALUSrcE",     {31'b0, bus.ALUSrcE},     {31'b0, e.alusrc});
          chk("ALUControlE", {29'b0, bus.ALUControlE}, {29'b0, e.aluc});
        end
        if (c == CARE_ALL) begin
          chk("RD1E",     bus.RD1E,     e.rd1);
          chk("RD2E",     bus.RD2E,     e.rd2);
          chk("PCE",      bus.PCE,      e.pc);
          chk("PCPlus4E", bus.PCPlus4E, e.pc4);
          chk("Rs1E", {27'b0, bus.Rs1E}, {27'b0, e.rs1});
          chk("Rs2E", {27'b0, bus.Rs2E}, {27'b0, e.rs2});
          chk("RdE",  {27'b0, bus.RdE},  {27'b0, e.rd});
          if (e.imm_care) chk("ImmExtE", bus.ImmExtE, e.imm);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic stl, input logic fls);
    bus.InstrD   = ins;
    bus.ValidD   = vld;
    bus.stall    = stl;
    bus.flush    = fls;
    bus.PCD      = $urandom() & 32'hFFFF_FFFC;
    bus.PCPlus4D = bus.PCD + 32'd4;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    bus.RegWriteW = rw;
    bus.RdW       = rdw;
    bus.ResultW   = res;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom();
    if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom_range(0, 127));
    else ins[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    int r;
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    bus.RD1 = '0;
    bus.RD2 = '0;
    set_wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    chk("rst_ValidE",     {31'b0, bus.ValidE}, 32'd0);
    chk("rst_ResultSrcE", {30'b0, bus.ResultSrcE}, 32'd0);
    chk("rst_ALUControl", {29'b0, bus.ALUControlE}, 32'd0);
    chk("rst_PCE",        bus.PCE, 32'd0);

    // add x3,x1,x2
    rst = 1'b0;
    drive(32'h002081B3, 1'b1, 1'b0, 1'b0);
    bus.RD1 = 32'h11;
    bus.RD2 = 32'h22;
    #1;
    chk("add_A1", {27'b0, bus.A1}, 32'd1);
    chk("add_A2", {27'b0, bus.A2}, 32'd2);
    step();
    chk("add_RegWriteE",   {31'b0, bus.RegWriteE}, 32'd1);
    chk("add_ALUSrcE",     {31'b0, bus.ALUSrcE}, 32'd0);
    chk("add_ALUControlE", {29'b0, bus.ALUControlE}, 32'd0);
    chk("add_RdE",         {27'b0, bus.RdE}, 32'd3);
    chk("add_RD1E",        bus.RD1E, 32'h11);

    // sw x6,-4(x5) with write-back of x5 in flight
    drive(32'hFE62AE23, 1'b1, 1'b0, 1'b0);
    bus.RD1 = 32'h5;
    bus.RD2 = 32'h66;
    set_wb(1'b1, 5'd5, 32'h1234);
    step();
    chk("sw_ImmExtE",   bus.ImmExtE, 32'hFFFF_FFFC);
    chk("sw_MemWriteE", {31'b0, bus.MemWriteE}, 32'd1);
    chk("sw_RegWriteE", {31'b0, bus.RegWriteE}, 32'd0);
    chk("sw_ALUSrcE",   {31'b0, bus.ALUSrcE}, 32'd1);
    chk("byp_RD1E",     bus.RD1E, 32'h1234);
    chk("byp_RD2E",     bus.RD2E, 32'h66);
    set_wb(1'b1, 5'd0, 32'h1234);
    step();
    chk("nobyp_RD1E", bus.RD1E, 32'h5);

    // stall holds the captured add while InstrD keeps changing
    set_wb(1'b0, 5'd0, 32'h0);
    drive(32'h002081B3, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(), 1'b1, 1'b1, 1'b0);
      step();
      chk("stall_RdE",       {27'b0, bus.RdE}, 32'd3);
      chk("stall_RegWriteE", {31'b0, bus.RegWriteE}, 32'd1);
      chk("stall_ValidE",    {31'b0, bus.ValidE}, 32'd1);
    end
    drive(32'h002081B3, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush_ValidE",    {31'b0, bus.ValidE}, 32'd0);
    chk("flush_RegWriteE", {31'b0, bus.RegWriteE}, 32'd0);

    // illegal opcode 0x7F with rd=x31
    drive(32'h00000FFF, 1'b1, 1'b0, 1'b0);
    step();
    chk("ill_IllegalE",  {31'b0, bus.IllegalE}, 32'd1);
    chk("ill_RegWriteE", {31'b0, bus.RegWriteE}, 32'd0);
    chk("ill_MemWriteE", {31'b0, bus.MemWriteE}, 32'd0);
    chk("ill_ValidE",    {31'b0, bus.ValidE}, 32'd1);

    // reset arriving with a valid jal x0,8
    drive(32'h0080006F, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("jrst_ValidE",   {31'b0, bus.ValidE}, 32'd0);
    chk("jrst_JumpE",    {31'b0, bus.JumpE}, 32'd0);
    chk("jrst_IllegalE", {31'b0, bus.IllegalE}, 32'd0);
    chk("jrst_ImmExtE",  bus.ImmExtE, 32'd0);
    rst = 1'b0;
    step();
    chk("jal_ValidE",     {31'b0, bus.ValidE}, 32'd1);
    chk("jal_JumpE",      {31'b0, bus.JumpE}, 32'd1);
    chk("jal_ImmExtE",    bus.ImmExtE, 32'd8);
    chk("jal_ResultSrcE", {30'b0, bus.ResultSrcE}, 32'd2);
    chk("jal_RegWriteE",  {31'b0, bus.RegWriteE}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      ins = rand_instr();
      r   = $urandom_range(0, 99);
      rst = (r == 0);
      drive(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10);
      bus.RD1 = $urandom();
      bus.RD2 = $urandom();
      r = $urandom_range(0, 3);
      set_wb($urandom_range(0, 3) != 0,
             (r < 2) ? ins[19:15] : (r == 2) ? ins[24:20] : 5'($urandom_range(0, 31)),
             $urandom());
      step();
    end

    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
